// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   IF_NOP_INSTR  : encoding presented to decode as a bubble
//   if_state_e    : fetch FSM states (IF_STATE_FETCH, IF_STATE_HOLD)
//   fetch_word_t  : {addr, instr} pair carried through the hold buffer
//   pc_inc()      : sequential PC step, wraps 16'hFFFF -> 16'h0000
package ifetch_pkg;

    localparam logic [15:0] IF_NOP_INSTR = 16'h0800;

    typedef enum logic {
        IF_STATE_FETCH = 1'b0,
        IF_STATE_HOLD  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] instr;
    } fetch_word_t;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry {addr, instr} buffer that parks a word fetched while decode is
// stalled.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture din (takes effect even if already full)
//   drain      : entry consumed, mark empty
//   flush      : drop the entry (priority over load/drain)
//   din, dout  : buffered word
//   full       : entry holds a real fetched word
module ifetch_hold_buf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  fetch_word_t din,
    output fetch_word_t dout,
    output logic        full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over req/ack and
// drives the IF/ID register. Branches have one delay slot; a branch seen in
// ID before its delay-slot word returns is remembered in pend/pend_pc.
//   clk, rst                      : clock, asynchronous active-high reset
//   ifi_pause                     : scheduler stall, IF/ID holds
//   ifi_branch, ifi_new_pc        : taken branch in ID and its target
//   ifi_int_redirect, ifi_int_pc  : flush + redirect (interrupt / ERET)
//   ifo_mem_req, ifo_mem_addr     : fetch request, address (= pc)
//   ifi_mem_ack, ifi_mem_data     : fetch completion and fetched word
//   ifo_addr, ifo_instr, ifo_valid: IF/ID register
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifi_pause,
    input  logic        ifi_branch,
    input  logic [15:0] ifi_new_pc,
    input  logic        ifi_int_redirect,
    input  logic [15:0] ifi_int_pc,
    output logic        ifo_mem_req,
    output logic [15:0] ifo_mem_addr,
    input  logic        ifi_mem_ack,
    input  logic [15:0] ifi_mem_data,
    output logic [15:0] ifo_addr,
    output logic [15:0] ifo_instr,
    output logic        ifo_valid
);

    if_state_e   state;
    logic [15:0] pc;
    logic [15:0] pend_pc;
    logic        pend;
    logic [15:0] next_pc;
    logic        ack;
    logic        in_fetch;
    logic        hb_load;
    logic        hb_drain;
    logic        hb_full;
    fetch_word_t hb_dout;

    assign in_fetch     = (state == IF_STATE_FETCH);
    // rst gates req combinationally so it drops the moment reset asserts
    assign ifo_mem_req  = in_fetch & ~rst;
    assign ifo_mem_addr = pc;
    assign ack          = ifi_mem_ack & in_fetch;

    // A branch still visible in ID wins over a previously latched target.
    always_comb begin
        next_pc = pc_inc(pc);
        if (ifi_branch)
            next_pc = ifi_new_pc;
        else if (pend)
            next_pc = pend_pc;
    end

    assign hb_load  = ~ifi_int_redirect & ack & ifi_pause;
    assign hb_drain = ~ifi_int_redirect & ~in_fetch & ~ifi_pause;

    ifetch_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hb_load),
        .drain (hb_drain),
        .flush (ifi_int_redirect),
        .din   ('{addr: pc, instr: ifi_mem_data}),
        .dout  (hb_dout),
        .full  (hb_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IF_STATE_FETCH;
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_pc   <= '0;
            ifo_valid <= 1'b0;
            ifo_instr <= NOP_INSTR;
            ifo_addr  <= '0;
        end else if (ifi_int_redirect) begin
            // Redirect beats pause and ack: in-flight data is discarded.
            state     <= IF_STATE_FETCH;
            pc        <= ifi_int_pc;
            pend      <= 1'b0;
            ifo_valid <= 1'b0;
            ifo_instr <= NOP_INSTR;
        end else begin
            case (state)
                IF_STATE_FETCH: begin
                    if (ack) begin
                        pc   <= next_pc;
                        pend <= 1'b0;
                        if (!ifi_pause) begin
                            ifo_addr  <= pc;
                            ifo_instr <= ifi_mem_data;
                            ifo_valid <= 1'b1;
                        end else begin
                            state <= IF_STATE_HOLD;
                        end
                    end else if (!ifi_pause) begin
                        ifo_valid <= 1'b0;
                        ifo_instr <= NOP_INSTR;
                        // Branch leaves ID this cycle but its delay slot is
                        // still outstanding: remember the target.
                        if (ifi_branch) begin
                            pend    <= 1'b1;
                            pend_pc <= ifi_new_pc;
                        end
                    end
                end
                IF_STATE_HOLD: begin
                    // pc already advanced at the ack; a branch still in ID
                    // was consumed then, so it is not latched here.
                    if (!ifi_pause) begin
                        ifo_addr  <= hb_dout.addr;
                        ifo_instr <= hb_dout.instr;
                        ifo_valid <= hb_full;
                        state     <= IF_STATE_FETCH;
                    end
                end
                default: state <= IF_STATE_FETCH;
            endcase
        end
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the 16-bit pipeline. It owns the PC and issues word fetches to instruction memory over a req/ack handshake, and it drives the IF/ID register that feeds the decode stage (`addr`, `instr`, `valid`). It takes branch redirects from decode and interrupt/ERET redirects from the scheduler. Branches have one architectural delay slot: the word after a branch always executes.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, first fetch address after reset
- `NOP_INSTR`, 16'h0800, encoding presented to decode as a bubble

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ifi_pause`  in  1  scheduler stall; IF/ID register holds
- `ifi_branch`  in  1  decode: instruction in ID is a taken branch
- `ifi_new_pc`  in  16  decode: branch target, valid with `ifi_branch`
- `ifi_int_redirect`  in  1  scheduler: flush and redirect (interrupt entry or ERET)
- `ifi_int_pc`  in  16  redirect target, valid with `ifi_int_redirect`
- `ifo_mem_req`  out  1  fetch request
- `ifo_mem_addr`  out  16  fetch address (equals PC)
- `ifi_mem_ack`  in  1  fetch done; `ifi_mem_data` valid this cycle; only meaningful while req is high
- `ifi_mem_data`  in  16  fetched word
- `ifo_addr`  out  16  address of instruction in IF/ID
- `ifo_instr`  out  16  instruction in IF/ID (`NOP_INSTR` when invalid)
- `ifo_valid`  out  1  IF/ID holds a real instruction

## Operation
- State: `pc`[15:0], `pend`/`pend_pc` (latched branch target), hold buffer (`hb_addr`, `hb_instr`), FSM {FETCH, HOLD}.
- Reset: pc=`RESET_PC`, FSM=FETCH, pend=0, ifo_valid=0, ifo_instr=`NOP_INSTR`, ifo_addr=0, ifo_mem_req=0, ifo_mem_addr=`RESET_PC`.
- `ifo_mem_req` = (FSM==FETCH) & !rst. `ifo_mem_addr` = pc.
- FETCH, ack, !pause: IF/ID <= {pc, data, valid=1}; pc <= next_pc; stay in FETCH.
- FETCH, ack, pause: hold buffer <= {pc, data}; pc <= next_pc; go to HOLD; IF/ID unchanged.
- FETCH, no ack, !pause: IF/ID <= bubble (valid=0, `NOP_INSTR`, addr unchanged).
- FETCH, no ack, pause: IF/ID unchanged.
- HOLD: req low. When !pause, IF/ID <= hold buffer with valid=1, then go to FETCH.
- next_pc: `ifi_branch` ? `ifi_new_pc` : pend ? `pend_pc` : pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000). Every ack clears pend.
- pend <= 1, pend_pc <= `ifi_new_pc` when `ifi_branch` & !pause & no ack.
- A paused branch stays visible in ID and is consumed directly by next_pc, so it is never latched twice.
- `ifi_int_redirect` has top priority, including over pause and ack:
  - same-cycle ack data is discarded
  - hold buffer is dropped, pend is cleared
  - IF/ID <= bubble
  - pc <= `ifi_int_pc`, FSM <= FETCH

## Timing
- A word acked in cycle t appears on ifo_* in t+1, or in the cycle after pause drops if paused.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
- After leaving HOLD there is one req-idle cycle.
- Branch penalty is zero beyond the delay slot: the target fetch is issued the cycle after the delay-slot ack.
- After a redirect, req is high the next cycle with addr=`ifi_int_pc`. The first valid instruction appears at the earliest 2 cycles after the redirect.
- If rst is asserted mid-fetch, req drops immediately (asynchronous). Any late ack is ignored.

## Structure
- Shared defines file: `NOP_INSTR` encoding and FSM state encodings (`IF_STATE_FETCH`, `IF_STATE_HOLD`), alongside the existing opcode defines.
- Optional sub-module `fetch_hold_buf`: one-entry {addr, instr} buffer with load/drain/flush controls.

## Test plan
- Reset, then zero-wait memory returning addr+16'h1000 -> ifo_valid=1 from cycle 2; ifo_addr steps 0,1,2,...; ifo_instr = 16'h1000,16'h1001,...
- Branch at 0x0004 with `ifi_new_pc`=0x0040, memory 3 wait states -> fetch order 4,5,0x40,0x41; bubbles on ifo while waiting; 0x0005 still reaches ID.
- Pause for 3 cycles asserted in the cycle 0x0007 is acked -> 0x0007 is held, req low during HOLD, 0x0007 presented once after release, no refetch or skipped address.
- `ifi_int_redirect` to 0x0100 in the same cycle as an ack of 0x0009 with pend set -> 0x0009 is discarded, next req addr=0x0100, pend cleared.
- pc at 16'hFFFF -> next fetch addr 16'h0000.
- rst asserted while req is high and ack pending -> req=0 at once; outputs return to reset values.
